fft_sequencer: RTL and testbench
================================

# fft_sequencer

Control sequencer for the 4-point FFT engine. It steps the design through idle, loading four samples, compute, and presenting four results. It debounce-synchronizes the two user pushbuttons and issues sample-write, compute-start and result-select controls to the datapath. It drives the 4-bit state code that the seven-segment display logic renders: blank, 1–4, C, 5–8.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop synchronizer depth per button input (≥2).
- TIMEOUT_CYCLES, 255: maximum cycles spent in COMPUTE awaiting compute_done (1..65535). Timer width is clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_btn  in  1  raw asynchronous pushbutton: start / load next sample.
- read_btn  in  1  raw asynchronous pushbutton: advance to next result.
- compute_done  in  1  synchronous one-cycle pulse from the butterfly datapath.
- state_code  out  4  registered display code: 0 IDLE, 1–4 LOAD0–3, 5 COMPUTE, 6–9 OUT0–3.
- sample_we  out  1  registered one-cycle write strobe for the sample buffer.
- sample_addr  out  2  registered sample buffer index, valid with sample_we.
- compute_start  out  1  registered one-cycle pulse on entry to COMPUTE.
- out_addr  out  2  registered result index; held while in OUTk.
- out_valid  out  1  high in OUT0–OUT3 only.
- err  out  1  sticky compute-timeout flag.

## Operation
- Button path: the raw button feeds s[0]. s[0] feeds s[SYNC_STAGES-1] through a register chain. prev is a register holding s[last]. The event signal is evt = s[last] & ~prev, combinational and one cycle wide per press. Releases generate nothing.
- Event names: ld_evt and rd_evt are the events from load_btn and read_btn. Both are 1 in the same cycle = abort.
- State register encoding equals state_code. Transitions:
  - IDLE: on ld_evt, go to LOAD0 without writing a sample; err clears. rd_evt is ignored.
  - LOADk: on ld_evt, assert sample_we=1 and sample_addr=k for the next cycle. Then go to LOAD(k+1), or from LOAD3 to COMPUTE. rd_evt alone is ignored.
  - COMPUTE: compute_start=1 in the first COMPUTE cycle only. The timer clears on entry and increments every COMPUTE cycle.
    - compute_done=1 (any COMPUTE cycle, including the first) → OUT0.
    - Timer reaching TIMEOUT_CYCLES without done → IDLE, with err=1.
    - Done and timeout in the same cycle: done wins.
    - Button events are ignored except abort.
  - OUTk: out_addr=k and out_valid=1. rd_evt → OUT(k+1); from OUT3 → IDLE. ld_evt alone is ignored.
- Abort: ld_evt and rd_evt in the same cycle in any non-IDLE state → IDLE.
  - No sample_we or compute_start is issued.
  - err is unchanged.
  - Abort in IDLE is ignored.
- compute_done outside COMPUTE is ignored.
- sample_we, compute_start and out_valid are never high simultaneously.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - State, synchronizers and prev are 0.
  - state_code=0, sample_we=0, sample_addr=0, compute_start=0, out_addr=0, out_valid=0, err=0.
- Reset mid-operation returns to IDLE and discards progress. Reset during a sample_we or compute_start pulse truncates it.
- A button held high across reset release yields exactly one event once the synchronizer fills.
- Button latency: load_btn is first sampled high at edge E1. ld_evt is high after edge E(SYNC_STAGES). State and sample_we update at edge E(SYNC_STAGES+1).
- sample_we and sample_addr assert in the same cycle that state_code advances to the next code.
- compute_start is high in the same cycle that state_code first reads 5.
- compute_done sampled at edge N: state_code=6, out_valid=1, out_addr=0 after edge N.
- Timeout: if compute_done never arrives, IDLE and err=1 appear exactly TIMEOUT_CYCLES edges after the edge that entered COMPUTE.
- A button held high produces one event only. A new press requires s[last] to return low for at least one cycle.

## Test plan
- Full flow with SYNC_STAGES=2:
  - Stimulus: 5 load presses, compute_done 10 cycles after compute_start, then 4 read presses.
  - Required response: state_code 0→1→2→3→4→5→6→7→8→9→0.
  - sample_we pulses at addr 0,1,2,3.
  - One compute_start.
  - out_addr 0..3 with out_valid.
- Press latency:
  - Stimulus: load_btn rises before edge 1 in IDLE.
  - Required response: state_code=1 after edge 3.
  - A second press while held high produces no further change.
- Timeout with TIMEOUT_CYCLES=8 and no compute_done:
  - Required response: IDLE and err=1 exactly 8 edges after COMPUTE entry.
  - The next load press clears err and enters LOAD0.
- Done/timeout race:
  - Stimulus: compute_done arrives on the cycle the timer reaches TIMEOUT_CYCLES.
  - Required response: OUT0 (code 6) and err=0.
- Abort:
  - Stimulus: both buttons pressed simultaneously in LOAD2.
  - Required response: IDLE, no sample_we.
  - Stimulus: both pressed in IDLE. Required response: remain at 0.
- Reset mid-operation:
  - Stimulus: rst_n low asynchronously mid-COMPUTE.
  - Required response: all outputs 0 immediately.
  - Stimulus: load_btn held through reset release. Required response: exactly one transition to LOAD0.

Source files
------------

// File: rtl/fft_sequencer.sv
// Purpose: control sequencer for the 4-point FFT engine (idle, load 4 samples, compute, show 4 results).
// Latency: button press acts SYNC_STAGES+1 edges after first sampled high; all outputs are registered.
// Backpressure: none; the datapath must accept sample_we/compute_start pulses when issued.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   load_btn, read_btn      raw asynchronous pushbuttons (start/load next, advance result)
//   compute_done            one-cycle pulse from the butterfly datapath
//   state_code              display code: 0 IDLE, 1-4 LOAD0-3, 5 COMPUTE, 6-9 OUT0-3
//   sample_we, sample_addr  one-cycle sample buffer write strobe and index
//   compute_start           one-cycle pulse in the first COMPUTE cycle
//   out_addr, out_valid     result index and valid, high in OUT0-OUT3
//   err                     sticky compute-timeout flag, cleared by the next start press
module fft_sequencer #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_btn,
   input  logic       read_btn,
   input  logic       compute_done,
   output logic [3:0] state_code,
   output logic       sample_we,
   output logic [1:0] sample_addr,
   output logic       compute_start,
   output logic [1:0] out_addr,
   output logic       out_valid,
   output logic       err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   // The state encoding is the display code, so state_code needs no decode.
   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_LOAD0   = 4'd1,
      ST_LOAD1   = 4'd2,
      ST_LOAD2   = 4'd3,
      ST_LOAD3   = 4'd4,
      ST_COMPUTE = 4'd5,
      ST_OUT0    = 4'd6,
      ST_OUT1    = 4'd7,
      ST_OUT2    = 4'd8,
      ST_OUT3    = 4'd9
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] ld_sync_q, rd_sync_q;
   logic                   ld_prev_q, rd_prev_q;
   logic                   ld_evt, rd_evt, abort;
   logic [TW-1:0]          timer_q, timer_d;
   logic                   timeout;
   logic                   sample_we_q, sample_we_d;
   logic [1:0]             sample_addr_q, sample_addr_d;
   logic                   compute_start_q, compute_start_d;
   logic [1:0]             out_addr_q, out_addr_d;
   logic                   out_valid_q, out_valid_d;
   logic                   err_q, err_d;

   // Synchronizer chains plus one history bit each; a press is the rising
   // edge of the synchronized level, so a held button gives a single event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_sync_q <= '0;
         rd_sync_q <= '0;
         ld_prev_q <= 1'b0;
         rd_prev_q <= 1'b0;
      end else begin
         ld_sync_q <= {ld_sync_q[SYNC_STAGES-2:0], load_btn};
         rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], read_btn};
         ld_prev_q <= ld_sync_q[SYNC_STAGES-1];
         rd_prev_q <= rd_sync_q[SYNC_STAGES-1];
      end
   end

   assign ld_evt = ld_sync_q[SYNC_STAGES-1] & ~ld_prev_q;
   assign rd_evt = rd_sync_q[SYNC_STAGES-1] & ~rd_prev_q;
   assign abort  = ld_evt & rd_evt;

   // Timer is zero outside COMPUTE, so it is already clear on entry. It holds
   // the number of COMPUTE cycles already completed; when it reads
   // TIMEOUT_CYCLES-1 the coming edge is the TIMEOUT_CYCLES-th since entry.
   always_comb begin
      timer_d = (state_q == ST_COMPUTE) ? timer_q + TW'(1) : '0;
   end

   assign timeout = (timer_q == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d         = state_q;
      sample_we_d     = 1'b0;
      sample_addr_d   = sample_addr_q;
      compute_start_d = 1'b0;
      err_d           = err_q;

      case (state_q)
         ST_IDLE: begin
            // Simultaneous presses in IDLE are not a start.
            if (ld_evt && !rd_evt) begin
               state_d = ST_LOAD0;
               err_d   = 1'b0;
            end
         end
         ST_LOAD0, ST_LOAD1, ST_LOAD2, ST_LOAD3: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (ld_evt) begin
               sample_we_d     = 1'b1;
               sample_addr_d   = 2'(state_q - ST_LOAD0);
               // LOAD3 + 1 is COMPUTE; the last write and the start pulse
               // share a cycle, and the datapath commits the write first.
               state_d         = state_t'(state_q + 4'd1);
               compute_start_d = (state_q == ST_LOAD3);
            end
         end
         ST_COMPUTE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (compute_done) begin
               state_d = ST_OUT0;
            end else if (timeout) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         ST_OUT0, ST_OUT1, ST_OUT2, ST_OUT3: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (rd_evt) begin
               state_d = (state_q == ST_OUT3) ? ST_IDLE : state_t'(state_q + 4'd1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      out_valid_d = (state_d >= ST_OUT0) && (state_d <= ST_OUT3);
      out_addr_d  = out_valid_d ? 2'(state_d - ST_OUT0) : 2'b00;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         timer_q         <= '0;
         sample_we_q     <= 1'b0;
         sample_addr_q   <= 2'b00;
         compute_start_q <= 1'b0;
         out_addr_q      <= 2'b00;
         out_valid_q     <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         timer_q         <= timer_d;
         sample_we_q     <= sample_we_d;
         sample_addr_q   <= sample_addr_d;
         compute_start_q <= compute_start_d;
         out_addr_q      <= out_addr_d;
         out_valid_q     <= out_valid_d;
         err_q           <= err_d;
      end
   end

   assign state_code    = state_q;
   assign sample_we     = sample_we_q;
   assign sample_addr   = sample_addr_q;
   assign compute_start = compute_start_q;
   assign out_addr      = out_addr_q;
   assign out_valid     = out_valid_q;
   assign err           = err_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Bench for fft_sequencer: two instances share stimulus, one with a long
// timeout (255) and one with a short timeout (8), checked every cycle
// against a phase/index reference model plus directed scenario checks.
module tb_fft_sequencer;

   localparam int S  = 2;
   localparam int T0 = 255;
   localparam int T1 = 8;

   localparam int P_IDLE = 0;
   localparam int P_LOAD = 1;
   localparam int P_COMP = 2;
   localparam int P_OUT  = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load_btn, read_btn, compute_done;
   logic [3:0] code   [2];
   logic       we     [2];
   logic [1:0] waddr  [2];
   logic       start  [2];
   logic [1:0] oaddr  [2];
   logic       ov     [2];
   logic       err_o  [2];

   always #5 clk = ~clk;

   fft_sequencer #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(T0)) dut0 (
      .clk(clk), .rst_n(rst_n), .load_btn(load_btn), .read_btn(read_btn),
      .compute_done(compute_done), .state_code(code[0]), .sample_we(we[0]),
      .sample_addr(waddr[0]), .compute_start(start[0]), .out_addr(oaddr[0]),
      .out_valid(ov[0]), .err(err_o[0])
   );

   fft_sequencer #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(T1)) dut1 (
      .clk(clk), .rst_n(rst_n), .load_btn(load_btn), .read_btn(read_btn),
      .compute_done(compute_done), .state_code(code[1]), .sample_we(we[1]),
      .sample_addr(waddr[1]), .compute_start(start[1]), .out_addr(oaddr[1]),
      .out_valid(ov[1]), .err(err_o[1])
   );

   int errors = 0;
   int checks = 0;
   int we_cnt = 0;
   int st_cnt = 0;

   task automatic check_val(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int ph [2];
   int k  [2];
   int cnt[2];
   int m_waddr[2];
   bit m_we[2];
   bit m_start[2];
   bit m_err[2];
   bit ld_h[$];
   bit rd_h[$];

   function automatic int tmo(input int i);
      return (i == 0) ? T0 : T1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         ph[i] = P_IDLE; k[i] = 0; cnt[i] = 0; m_waddr[i] = 0;
         m_we[i] = 0; m_start[i] = 0; m_err[i] = 0;
      end
      ld_h.delete();
      rd_h.delete();
      for (int j = 0; j < S + 2; j++) begin
         ld_h.push_back(1'b0);
         rd_h.push_back(1'b0);
      end
   endtask

   task automatic model_fsm(input int i, input bit le, input bit re, input bit dn);
      bit ab;
      ab = le && re;
      m_we[i] = 0;
      m_start[i] = 0;
      case (ph[i])
         P_IDLE: if (le && !re) begin ph[i] = P_LOAD; k[i] = 0; m_err[i] = 0; end
         P_LOAD: begin
            if (ab) ph[i] = P_IDLE;
            else if (le) begin
               m_we[i] = 1; m_waddr[i] = k[i];
               if (k[i] == 3) begin ph[i] = P_COMP; cnt[i] = 0; m_start[i] = 1; end
               else k[i]++;
            end
         end
         P_COMP: begin
            cnt[i]++;   // edges elapsed since COMPUTE was entered
            if (ab) ph[i] = P_IDLE;
            else if (dn) begin ph[i] = P_OUT; k[i] = 0; end
            else if (cnt[i] == tmo(i)) begin ph[i] = P_IDLE; m_err[i] = 1; end
         end
         P_OUT: begin
            if (ab) ph[i] = P_IDLE;
            else if (re) begin
               if (k[i] == 3) ph[i] = P_IDLE;
               else k[i]++;
            end
         end
         default: ph[i] = P_IDLE;
      endcase
   endtask

   // An event at this edge comes from the button level sampled S edges ago
   // being high while the level sampled S+1 edges ago was low.
   task automatic model_edge();
      bit le, re;
      if (!rst_n) begin
         model_reset();
         return;
      end
      ld_h.push_front(load_btn);
      rd_h.push_front(read_btn);
      void'(ld_h.pop_back());
      void'(rd_h.pop_back());
      le = ld_h[S] && !ld_h[S+1];
      re = rd_h[S] && !rd_h[S+1];
      for (int i = 0; i < 2; i++) model_fsm(i, le, re, compute_done);
   endtask

   function automatic int exp_code(input int i);
      case (ph[i])
         P_LOAD:  return 1 + k[i];
         P_COMP:  return 5;
         P_OUT:   return 6 + k[i];
         default: return 0;
      endcase
   endfunction

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         check_val($sformatf("code%0d", i), code[i], exp_code(i));
         check_val($sformatf("we%0d", i), we[i], m_we[i]);
         check_val($sformatf("start%0d", i), start[i], m_start[i]);
         check_val($sformatf("ovalid%0d", i), ov[i], (ph[i] == P_OUT) ? 1 : 0);
         check_val($sformatf("err%0d", i), err_o[i], m_err[i]);
         check_val($sformatf("excl%0d", i), ov[i] & (we[i] | start[i]), 0);
         if (m_we[i]) check_val($sformatf("waddr%0d", i), waddr[i], m_waddr[i]);
         if (ph[i] == P_OUT) check_val($sformatf("oaddr%0d", i), oaddr[i], k[i]);
      end
      we_cnt += int'(we[0]);
      st_cnt += int'(start[0]);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic press(input bit l, input bit r);
      load_btn = l;
      read_btn = r;
      step();
      load_btn = 1'b0;
      read_btn = 1'b0;
      repeat (S + 1) step();
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         check_val($sformatf("%s_code%0d", tag, i), code[i], 0);
         check_val($sformatf("%s_outs%0d", tag, i),
                   {we[i], waddr[i], start[i], oaddr[i], ov[i], err_o[i]}, 0);
      end
   endtask

   // Asynchronous reset between edges; outputs must clear without a clock.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      model_reset();
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      load_btn = 1'b0;
      read_btn = 1'b0;
      compute_done = 1'b0;
      model_reset();
      repeat (2) step();
      check_all_zero("reset");
      rst_n = 1'b1;

      // Full flow: 5 loads, done 10 edges after compute entry, 4 reads.
      we_cnt = 0;
      st_cnt = 0;
      for (int p = 0; p < 5; p++) begin
         press(1'b1, 1'b0);
         check_val("flow_load_code", code[0], p + 1);
      end
      repeat (8) step();
      compute_done = 1'b1;
      step();
      compute_done = 1'b0;
      check_val("flow_out0_code", code[0], 6);
      check_val("flow_out0_valid", ov[0], 1);
      check_val("flow_out0_addr", oaddr[0], 0);
      for (int p = 0; p < 4; p++) begin
         press(1'b0, 1'b1);
         check_val("flow_read_code", code[0], (p < 3) ? 7 + p : 0);
      end
      check_val("flow_we_count", we_cnt, 4);
      check_val("flow_start_count", st_cnt, 1);

      // Press latency: high before edge 1, LOAD0 after edge 3, held = one event.
      do_reset();
      load_btn = 1'b1;
      step(); check_val("lat_e1", code[0], 0);
      step(); check_val("lat_e2", code[0], 0);
      step(); check_val("lat_e3", code[0], 1);
      repeat (6) step();
      check_val("lat_held", code[0], 1);
      load_btn = 1'b0;
      repeat (3) step();

      // Timeout on the short-timeout instance.
      do_reset();
      repeat (5) press(1'b1, 1'b0);
      repeat (6) step();
      check_val("to_before", code[1], 5);
      step();
      check_val("to_code", code[1], 0);
      check_val("to_err", err_o[1], 1);
      press(1'b1, 1'b0);
      check_val("to_restart_code", code[1], 1);
      check_val("to_restart_err", err_o[1], 0);

      // Done arriving on the timeout edge wins.
      do_reset();
      repeat (5) press(1'b1, 1'b0);
      repeat (6) step();
      compute_done = 1'b1;
      step();
      compute_done = 1'b0;
      check_val("race_code", code[1], 6);
      check_val("race_err", err_o[1], 0);

      // Abort in LOAD2, then both buttons in IDLE.
      do_reset();
      repeat (3) press(1'b1, 1'b0);
      check_val("abort_pre", code[0], 3);
      we_cnt = 0;
      press(1'b1, 1'b1);
      check_val("abort_code", code[0], 0);
      check_val("abort_no_we", we_cnt, 0);
      press(1'b1, 1'b1);
      check_val("abort_idle_code", code[0], 0);

      // Reset mid-COMPUTE with load held through release.
      do_reset();
      repeat (5) press(1'b1, 1'b0);
      repeat (2) step();
      load_btn = 1'b1;
      do_reset();
      repeat (10) step();
      check_val("rst_hold_code", code[0], 1);
      load_btn = 1'b0;
      repeat (3) step();

      // Randomized traffic checked cycle by cycle against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         load_btn     = ($urandom_range(0, 3) == 0);
         read_btn     = ($urandom_range(0, 3) == 0);
         compute_done = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 499) == 0) do_reset();
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
